// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA timing generator: pixel-enable divider, h/v counters, registered syncs
// Sync outputs are registered from the next count so they stay aligned with pix_x/pix_y.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_RETRACE = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_RETRACE = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]       HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]       HS_END   = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [9:0]       VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]       VS_END   = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);
    localparam logic [9:0]       FT_LINE  = 10'(V_DISPLAY + 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;
    logic             w_tick;

    assign w_tick = (r_div == DIV_MAX);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            if (r_x == H_MAX) begin
                w_x_next = '0;
                w_y_next = (r_y == V_MAX) ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            // Decode from the next count so the pulse edge lands on the same clock as the count.
            r_hsync <= ~((w_x_next >= HS_START) && (w_x_next <= HS_END));
            r_vsync <= ~((w_y_next >= VS_START) && (w_y_next <= VS_END));
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign pix_x      = r_x;
    assign pix_y      = r_y;
    assign p_tick     = w_tick;
    assign video_on   = (r_x < H_VIS) && (r_y < V_VIS);
    assign frame_tick = w_tick && (r_x == 10'd0) && (r_y == FT_LINE);

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - scoreboard bench for vga_sync: default, reduced-frame and override instances
module tb_vga_sync;
    logic clk;
    logic rst_n;
    logic rst_s;

    logic       hs, vs, von, pt, ft;
    logic [9:0] px, py;
    logic       s_hs, s_vs, s_von, s_pt, s_ft;
    logic [9:0] s_px, s_py;
    logic       o_hs, o_vs, o_von, o_pt, o_ft;
    logic [9:0] o_px, o_py;

    int n_checks = 0;
    int n_fail   = 0;

    vga_sync u_dut (
        .clk(clk), .reset(rst_n), .hsync(hs), .vsync(vs), .video_on(von),
        .p_tick(pt), .frame_tick(ft), .pix_x(px), .pix_y(py)
    );

    // Reduced frame: H_TOTAL = 15 (hsync low x 10..12), V_TOTAL = 12 (vsync low y 8..9), frame_tick at y 7
    vga_sync #(
        .H_DISPLAY(8), .H_FRONT(2), .H_RETRACE(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_RETRACE(2), .V_BACK(2), .CLK_DIV(2)
    ) u_small (
        .clk(clk), .reset(rst_s), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .p_tick(s_pt), .frame_tick(s_ft), .pix_x(s_px), .pix_y(s_py)
    );

    vga_sync #(.CLK_DIV(2), .H_DISPLAY(320)) u_ovr (
        .clk(clk), .reset(rst_n), .hsync(o_hs), .vsync(o_vs), .video_on(o_von),
        .p_tick(o_pt), .frame_tick(o_ft), .pix_x(o_px), .pix_y(o_py)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int n;
        int x;
        int y;
        int hs;
        int vs;
        int von;
    } exp_t;

    exp_t sb[$];

    int tick_n   = 0;
    int prev_x   = 0;
    int step_err = 0;
    int hs_low   = 0;
    int von_cnt  = 0;

    // Monitor: every p_tick of the default instance is one presented sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && pt) begin
                tick_n++;
                if (tick_n >= 2 && tick_n <= 801) begin
                    if (int'(px) != ((prev_x == 799) ? 0 : prev_x + 1)) step_err++;
                end
                if (tick_n <= 800) begin
                    if (!hs) hs_low++;
                    if (von) von_cnt++;
                end
                prev_x = int'(px);
                if (sb.size() > 0 && sb[0].n == tick_n) begin
                    e = sb.pop_front();
                    check($sformatf("tick%0d_x", e.n), int'(px), e.x);
                    check($sformatf("tick%0d_y", e.n), int'(py), e.y);
                    check($sformatf("tick%0d_hsync", e.n), int'(hs), e.hs);
                    check($sformatf("tick%0d_vsync", e.n), int'(vs), e.vs);
                    check($sformatf("tick%0d_video_on", e.n), int'(von), e.von);
                end
            end
        end
    end

    initial begin
        int pulses;
        int vs_low, vs_bad, ft_cnt, s_von_cnt, wrap_seen, found, ticks, ov_von, ov_err;
        logic prev_pt;

        rst_n = 1'b0;
        rst_s = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", int'(px), 0);
        check("rst_y", int'(py), 0);
        check("rst_hsync", int'(hs), 1);
        check("rst_vsync", int'(vs), 1);
        check("rst_video_on", int'(von), 1);
        check("rst_p_tick", int'(pt), 0);
        check("rst_frame_tick", int'(ft), 0);

        //            n    x    y  hs vs von
        sb.push_back('{  1,   0, 0, 1, 1, 1});
        sb.push_back('{640, 639, 0, 1, 1, 1});
        sb.push_back('{641, 640, 0, 1, 1, 0});
        sb.push_back('{656, 655, 0, 1, 1, 0});
        sb.push_back('{657, 656, 0, 0, 1, 0});
        sb.push_back('{752, 751, 0, 0, 1, 0});
        sb.push_back('{753, 752, 0, 1, 1, 0});
        sb.push_back('{800, 799, 0, 1, 1, 0});
        sb.push_back('{801,   0, 1, 1, 1, 1});

        rst_n = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("p_tick_cycle%0d", c), int'(pt), (c % 4 == 0) ? 1 : 0);
            if (pt) pulses++;
            @(negedge clk);
        end
        check("p_tick_pulses_40", pulses, 10);

        for (int i = 0; i < 3500 && tick_n < 801; i++) @(negedge clk);
        check("line_done_timeout", (tick_n >= 801) ? 1 : 0, 1);
        check("line_x_steps", step_err, 0);
        check("line_hsync_low_ticks", hs_low, 96);
        check("line_video_on_ticks", von_cnt, 640);
        check("scoreboard_drained", sb.size(), 0);

        // Reduced frame: 360 clks is exactly one frame at CLK_DIV = 2
        vs_low = 0; vs_bad = 0; ft_cnt = 0; s_von_cnt = 0; wrap_seen = 0;
        rst_s = 1'b1;
        for (int i = 1; i <= 360; i++) begin
            @(negedge clk);
            if (wrap_seen == 1) begin
                check("wrap_x", int'(s_px), 0);
                check("wrap_y", int'(s_py), 0);
                check("wrap_hsync", int'(s_hs), 1);
                check("wrap_vsync", int'(s_vs), 1);
                check("wrap_video_on", int'(s_von), 1);
                wrap_seen = 2;
            end
            if (s_pt) begin
                if (!s_vs) begin
                    vs_low++;
                    if (s_py != 10'd8 && s_py != 10'd9) vs_bad++;
                end
                if (s_von) s_von_cnt++;
                if (s_ft) begin
                    ft_cnt++;
                    check("frame_tick_x", int'(s_px), 0);
                    check("frame_tick_y", int'(s_py), 7);
                end
                if (s_px == 10'd14 && s_py == 10'd11 && wrap_seen == 0) wrap_seen = 1;
            end
        end
        check("frame_end_x", int'(s_px), 0);
        check("frame_end_y", int'(s_py), 0);
        check("frame_vsync_low_ticks", vs_low, 30);
        check("frame_vsync_low_outside", vs_bad, 0);
        check("frame_tick_count", ft_cnt, 1);
        check("frame_video_on_ticks", s_von_cnt, 48);
        check("wrap_observed", wrap_seen, 2);

        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (s_px == 10'd11 && s_py == 10'd9) found = 1;
        end
        check("midreset_reached", found, 1);
        check("midreset_pre_hsync", int'(s_hs), 0);
        check("midreset_pre_vsync", int'(s_vs), 0);
        rst_s = 1'b0;
        #1;
        check("midreset_x", int'(s_px), 0);
        check("midreset_y", int'(s_py), 0);
        check("midreset_hsync", int'(s_hs), 1);
        check("midreset_vsync", int'(s_vs), 1);
        check("midreset_p_tick", int'(s_pt), 0);
        check("midreset_frame_tick", int'(s_ft), 0);

        // Override instance: period 2 and 320 visible pixels out of 480
        @(negedge clk);
        pulses = 0; ov_err = 0; prev_pt = o_pt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_pt) pulses++;
            if (o_pt == prev_pt) ov_err++;
            prev_pt = o_pt;
        end
        check("ovr_p_tick_pulses_20", pulses, 10);
        check("ovr_p_tick_alternates", ov_err, 0);

        found = 0;
        for (int i = 0; i < 1200 && found == 0; i++) begin
            @(negedge clk);
            if (o_pt && o_px == 10'd0) found = 1;
        end
        check("ovr_line_start", found, 1);
        ticks = 0; ov_von = 0;
        for (int i = 0; i < 1000 && ticks < 480; i++) begin
            if (o_pt) begin
                ticks++;
                if (o_von) ov_von++;
            end
            if (ticks < 480) @(negedge clk);
        end
        check("ovr_line_ticks", ticks, 480);
        check("ovr_video_on_ticks", ov_von, 320);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
